// File: rtl/cooler_arbiter.sv
// Shared cooling-plant arbiter: round-robin scan admits one zone per cycle
// against a speed budget, with per-zone compressor cooldown after release.
module cooler_arbiter #(
  parameter int unsigned MIN_OFF = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] crs_req,
  input  logic [5:0]  budget,
  output logic [3:0]  grant,
  output logic [15:0] crs,
  output logic [5:0]  load,
  output logic        err
);

  localparam int unsigned NZ = 4;
  localparam int unsigned SW = 4;
  localparam int unsigned LW = 6;
  localparam int unsigned FW = LW + 1;
  localparam int unsigned CW = 4;

  logic [1:0]    ptr;
  logic [CW-1:0] cd [NZ];

  logic [NZ-1:0] rel_c;
  logic [LW-1:0] rel_sum_c;
  logic [LW-1:0] kept_load_c;
  logic [SW-1:0] sel_spd_c;
  logic          sel_legal_c;
  logic          sel_cand_c;
  logic [FW-1:0] fit_sum_c;
  logic          admit_c;
  logic          illegal_c;

  // Releases first, then the fit test for the scanned zone uses the post-release load.
  always_comb begin
    rel_c     = grant & ~req;
    rel_sum_c = '0;
    for (int i = 0; i < NZ; i++) begin
      if (rel_c[i]) rel_sum_c = rel_sum_c + LW'(crs[i*SW +: SW]);
    end
    kept_load_c = load - rel_sum_c;
    sel_spd_c   = crs_req[{ptr, 2'b00} +: SW];
    sel_legal_c = (sel_spd_c == 4'd4) || (sel_spd_c == 4'd6) || (sel_spd_c == 4'd8);
    sel_cand_c  = req[ptr] && !grant[ptr];
    fit_sum_c   = FW'(kept_load_c) + FW'(sel_spd_c);
    admit_c     = sel_cand_c && (cd[ptr] == '0) && sel_legal_c && (fit_sum_c <= FW'(budget));
    illegal_c   = sel_cand_c && !sel_legal_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      grant <= '0;
      crs   <= '0;
      load  <= '0;
      err   <= 1'b0;
      for (int i = 0; i < NZ; i++) cd[i] <= '0;
    end else begin
      ptr  <= ptr + 2'd1;
      err  <= illegal_c;
      load <= kept_load_c + (admit_c ? LW'(sel_spd_c) : LW'(0));
      for (int i = 0; i < NZ; i++) begin
        if (rel_c[i]) begin
          grant[i]          <= 1'b0;
          crs[i*SW +: SW]   <= '0;
          cd[i]             <= CW'(MIN_OFF);
        end else begin
          if (cd[i] != '0) cd[i] <= cd[i] - CW'(1);
          if (admit_c && (ptr == 2'(i))) begin
            grant[i]        <= 1'b1;
            crs[i*SW +: SW] <= sel_spd_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cooler_arbiter.sv
// Scoreboard bench for cooler_arbiter: a behavioural plant model predicts every
// cycle's outputs, plus directed end-state checks per scenario.
module tb_cooler_arbiter;

  localparam int MIN_OFF = 8;

  logic        clk;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] crs_req = '0;
  logic [5:0]  budget = '0;
  logic [3:0]  grant;
  logic [15:0] crs;
  logic [5:0]  load;
  logic        err;

  cooler_arbiter #(.MIN_OFF(MIN_OFF)) dut (
    .clk(clk), .reset(reset), .req(req), .crs_req(crs_req), .budget(budget),
    .grant(grant), .crs(crs), .load(load), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]  g;
    logic [15:0] c;
    logic [5:0]  l;
    logic        e;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  bit [3:0] m_grant;
  int m_spd[4];
  int m_cd[4];
  int m_ptr;
  bit m_err;

  task automatic model_clear();
    m_grant = '0;
    m_ptr = 0;
    m_err = 0;
    for (int i = 0; i < 4; i++) begin
      m_spd[i] = 0;
      m_cd[i] = 0;
    end
  endtask

  // Predict the next edge's outputs from current model state and driven inputs.
  task automatic model_step();
    int held, rel_total, p, s, tot;
    bit cand, legal, admit;
    exp_t e;
    held = 0;
    rel_total = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_grant[i]) begin
        held += m_spd[i];
        if (!req[i]) rel_total += m_spd[i];
      end
    end
    p = m_ptr;
    s = int'((crs_req >> (4 * p)) & 16'hF);
    legal = (s == 4) || (s == 6) || (s == 8);
    cand = req[p] && !m_grant[p];
    admit = cand && (m_cd[p] == 0) && legal && ((held - rel_total + s) <= int'(budget));
    m_err = cand && !legal;
    for (int i = 0; i < 4; i++) begin
      if (m_grant[i] && !req[i]) begin
        m_grant[i] = 1'b0;
        m_spd[i] = 0;
        m_cd[i] = MIN_OFF;
      end else if (m_cd[i] > 0) begin
        m_cd[i] = m_cd[i] - 1;
      end
    end
    if (admit) begin
      m_grant[p] = 1'b1;
      m_spd[p] = s;
    end
    m_ptr = (m_ptr + 1) % 4;
    tot = 0;
    e.c = '0;
    for (int i = 0; i < 4; i++) begin
      tot += m_spd[i];
      e.c = e.c | (16'(m_spd[i]) << (4 * i));
    end
    e.g = m_grant;
    e.l = 6'(tot);
    e.e = m_err;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] r, input logic [15:0] c, input logic [5:0] b);
    @(negedge clk);
    reset = 1'b0;
    req = r;
    crs_req = c;
    budget = b;
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    crs_req = '0;
    budget = '0;
    q.delete();
    model_clear();
  endtask

  // Scoreboard consumer: one expected entry per clocked cycle out of reset.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (grant !== e.g) begin
        n_fail++;
        $display("FAIL sb_grant @%0t: got %b expected %b", $time, grant, e.g);
      end
      n_checks++;
      if (crs !== e.c) begin
        n_fail++;
        $display("FAIL sb_crs @%0t: got %h expected %h", $time, crs, e.c);
      end
      n_checks++;
      if (load !== e.l) begin
        n_fail++;
        $display("FAIL sb_load @%0t: got %0d expected %0d", $time, load, e.l);
      end
      n_checks++;
      if (err !== e.e) begin
        n_fail++;
        $display("FAIL sb_err @%0t: got %b expected %b", $time, err, e.e);
      end
    end
  end

  task automatic test_reset();
    model_clear();
    repeat (3) @(negedge clk);
    n_checks++;
    if (grant !== 4'b0 || crs !== 16'h0 || load !== 6'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got g=%b c=%h l=%0d e=%b expected all zero", grant, crs, load, err);
    end
  endtask

  task automatic test_single_grant();
    apply_reset();
    drive(4'b0001, 16'h0008, 6'd20);
    settle();
    n_checks++;
    if (grant !== 4'b0001 || crs !== 16'h0008 || load !== 6'd8) begin
      n_fail++;
      $display("FAIL single_grant: got g=%b c=%h l=%0d expected 0001/0008/8", grant, crs, load);
    end
  endtask

  task automatic test_capacity();
    apply_reset();
    repeat (12) drive(4'b0111, 16'h0668, 6'd14);
    settle();
    n_checks++;
    if (grant !== 4'b0011 || load !== 6'd14) begin
      n_fail++;
      $display("FAIL capacity_full: got g=%b l=%0d expected 0011/14", grant, load);
    end
    repeat (6) drive(4'b0110, 16'h0668, 6'd14);
    settle();
    n_checks++;
    if (grant !== 4'b0110 || load !== 6'd12 || crs !== 16'h0660) begin
      n_fail++;
      $display("FAIL capacity_refill: got g=%b l=%0d c=%h expected 0110/12/0660", grant, load, crs);
    end
  endtask

  task automatic test_exact_fit();
    apply_reset();
    repeat (8) drive(4'b0011, 16'h0068, 6'd13);
    settle();
    n_checks++;
    if (grant !== 4'b0001 || load !== 6'd8) begin
      n_fail++;
      $display("FAIL over_by_one: got g=%b l=%0d expected 0001/8", grant, load);
    end
    repeat (4) drive(4'b0011, 16'h0068, 6'd14);
    settle();
    n_checks++;
    if (grant !== 4'b0011 || load !== 6'd14) begin
      n_fail++;
      $display("FAIL exact_fit: got g=%b l=%0d expected 0011/14", grant, load);
    end
  endtask

  task automatic test_cooldown();
    int w;
    apply_reset();
    drive(4'b0010, 16'h0060, 6'd20);
    drive(4'b0010, 16'h0060, 6'd20);
    settle();
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL cd_first_grant: got %b expected 0010", grant);
    end
    drive(4'b0000, 16'h0060, 6'd20);
    settle();
    n_checks++;
    if (grant !== 4'b0000 || load !== 6'd0) begin
      n_fail++;
      $display("FAIL cd_release: got g=%b l=%0d expected 0000/0", grant, load);
    end
    for (int k = 0; k < MIN_OFF; k++) begin
      drive(4'b0010, 16'h0060, 6'd20);
      settle();
      n_checks++;
      if (grant[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL cd_hold cycle %0d: got %b expected 0", k, grant[1]);
      end
    end
    w = 0;
    for (int k = 1; k <= 8; k++) begin
      drive(4'b0010, 16'h0060, 6'd20);
      settle();
      if (grant[1] === 1'b1) begin
        w = k;
        break;
      end
    end
    n_checks++;
    if (w != 3 || load !== 6'd6) begin
      n_fail++;
      $display("FAIL cd_regrant: got wait=%0d l=%0d expected 3/6", w, load);
    end
  endtask

  task automatic test_illegal();
    int pulses;
    bit seen_grant;
    apply_reset();
    pulses = 0;
    seen_grant = 0;
    for (int k = 0; k < 8; k++) begin
      drive(4'b1000, 16'h5000, 6'd30);
      settle();
      if (err === 1'b1) pulses++;
      if (grant[3] === 1'b1) seen_grant = 1;
    end
    n_checks++;
    if (pulses != 2 || seen_grant || load !== 6'd0) begin
      n_fail++;
      $display("FAIL illegal_speed: got pulses=%0d grant3=%b l=%0d expected 2/0/0", pulses, seen_grant, load);
    end
  endtask

  task automatic test_budget_drop();
    apply_reset();
    repeat (2) drive(4'b0011, 16'h0088, 6'd20);
    settle();
    n_checks++;
    if (grant !== 4'b0011 || load !== 6'd16) begin
      n_fail++;
      $display("FAIL bd_setup: got g=%b l=%0d expected 0011/16", grant, load);
    end
    repeat (8) drive(4'b0111, 16'h0488, 6'd10);
    settle();
    n_checks++;
    if (grant !== 4'b0011 || load !== 6'd16 || crs !== 16'h0088) begin
      n_fail++;
      $display("FAIL bd_no_preempt: got g=%b l=%0d c=%h expected 0011/16/0088", grant, load, crs);
    end
    repeat (4) drive(4'b0101, 16'h0488, 6'd10);
    settle();
    n_checks++;
    if (grant !== 4'b0001 || load !== 6'd8) begin
      n_fail++;
      $display("FAIL bd_still_blocked: got g=%b l=%0d expected 0001/8", grant, load);
    end
    repeat (4) drive(4'b0100, 16'h0488, 6'd10);
    settle();
    n_checks++;
    if (grant !== 4'b0100 || load !== 6'd4 || crs !== 16'h0400) begin
      n_fail++;
      $display("FAIL bd_admit: got g=%b l=%0d c=%h expected 0100/4/0400", grant, load, crs);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3) drive(4'b0111, 16'h0668, 6'd30);
    @(posedge clk);
    #2;
    n_checks++;
    if (grant !== 4'b0111 || load !== 6'd20) begin
      n_fail++;
      $display("FAIL ar_setup: got g=%b l=%0d expected 0111/20", grant, load);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || load !== 6'd0 || crs !== 16'h0000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_immediate: got g=%b l=%0d c=%h e=%b expected zeros", grant, load, crs, err);
    end
    q.delete();
    model_clear();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_capacity();
    test_exact_fit();
    test_cooldown();
    test_illegal();
    test_budget_drop();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cooler_arbiter.md
COOLER_ARBITER -- requirements
Module: cooler_arbiter

Interface
REQ-001 Parameter MIN_OFF, default 8, meaning compressor-protection cooldown in cycles after a zone is released before it may be re-granted (range 1..15).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 req  input  4  per-zone cooling request, bit i = zone i (level, held while cooling wanted).
REQ-005 crs_req  input  16  requested cooler speed per zone, zone i in bits [4i+3:4i]; legal values 4, 6, 8.
REQ-006 budget  input  6  total cooler-speed capacity of the shared plant, unsigned.
REQ-007 grant  output  4  registered, bit i high while zone i owns cooling capacity.
REQ-008 crs  output  16  registered granted speed per zone, same packing as crs_req; 0 for ungranted zones.
REQ-009 load  output  6  registered sum of crs over all granted zones.
REQ-010 err  output  1  registered one-cycle pulse on illegal speed request.

Function
REQ-011 Scan pointer ptr (2 bits) SHALL advance by 1 every cycle, wrapping 3 -> 0, regardless of grant outcome.
REQ-012 Per zone, cooldown counter cd[i] (4 bits) SHALL decrement by 1 each cycle while nonzero, saturating at 0.
REQ-013 Release: on any edge where grant[i]=1 and req[i]=0, grant[i]->0, crs[i]->0, cd[i]->MIN_OFF, load reduced by the released speed.
REQ-014 Admission evaluated only for zone ptr: requires req[ptr]=1, grant[ptr]=0, cd[ptr]=0, crs_req[ptr] legal, and (load after same-cycle releases + crs_req[ptr]) <= budget.
REQ-015 On admission, grant[ptr]->1 and crs[ptr] latches crs_req[ptr] on the same edge; load increases by that value; latency from qualifying scan cycle to grant visible = 1 edge.
REQ-016 Releases and one admission in the same cycle SHALL both take effect; load updates as old load - released + admitted.
REQ-017 While granted, changes to crs_req[i] SHALL be ignored; crs[i] holds latched value until release.
REQ-018 Illegal speed (not 4, 6, 8) on scanned zone with req=1 and grant=0: no grant, err pulses high for exactly one cycle.
REQ-019 Budget reduction below current load SHALL NOT preempt granted zones; admissions blocked until the fit test of REQ-014 passes.
REQ-020 Exact fit (sum equals budget) SHALL admit; exceeding by 1 SHALL NOT.
REQ-021 A zone denied for lack of capacity or cooldown retries on its next scan turn (every 4 cycles); no queueing state beyond ptr.
REQ-022 load SHALL always equal the sum of the four crs fields; maximum 32, no overflow in 6 bits.

Reset
REQ-023 While reset=1: grant=0, crs=0, load=0, err=0, ptr=0, all cd=0; asserting mid-operation drops all grants immediately without cooldown loading.
REQ-024 First scan after reset deassertion SHALL examine zone 0.

Verification
REQ-025 budget=20, req=0001, crs_req zone0=8 -> grant=0001 one edge after ptr=0 scan, crs zone0=8, load=8.
REQ-026 budget=14, zones 0..2 request 8,6,6 -> zone0, zone1 granted (load=14), zone2 denied each scan until zone0 releases, then granted with load=12.
REQ-027 Zone1 granted, req[1] dropped -> grant[1]=0 next edge; req[1] reasserted immediately -> no grant before MIN_OFF=8 cycles elapse, granted on first scan of zone1 after cd[1]=0.
REQ-028 Zone3 requests crs_req=5 -> err single-cycle pulse on each zone3 scan, grant[3] never set, load unchanged.
REQ-029 Load=16 granted, budget lowered to 10 -> grants retained, load=16; new request of 4 denied until load+4<=10.
REQ-030 Reset pulsed asynchronously mid-cycle with three zones granted -> grant=0, load=0, crs=0 immediately, before next clk edge.
